// File: rtl/audio_pkg.sv
// Shared constants and frame helpers for the I2S audio output stage.
package audio_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_WORD_W     = 24;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_PAD_W      = I2S_SLOT_BITS - I2S_WORD_W;

    localparam logic [5:0] I2S_BITCNT_RST = 6'd63;

    typedef logic [I2S_WORD_W-1:0]     dac_word_t;
    typedef logic [I2S_FRAME_BITS-1:0] frame_t;

    // Each 32-bit slot holds a left-justified 24-bit word followed by zero padding.
    function automatic frame_t pack_frame(dac_word_t left_word, dac_word_t right_word);
        return {left_word, {I2S_PAD_W{1'b0}}, right_word, {I2S_PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/audio_sample_conv.sv
// Converts one signed PSG sample to a 24-bit DAC word (sign-extend, gain shift, reduce).
// Define AUDIO_I2S_SATURATE_EN to clamp overflowing values instead of wrapping them.
module audio_sample_conv
    import audio_pkg::*;
#(
    parameter int IN_W       = 19,
    parameter int GAIN_SHIFT = 5
) (
    input  logic [IN_W-1:0]       sample_i,
    output logic [I2S_WORD_W-1:0] word_o
);

`ifdef AUDIO_I2S_SATURATE_EN
    localparam int EXT_W = I2S_WORD_W + GAIN_SHIFT;

    logic signed [EXT_W-1:0] shifted;
    logic [EXT_W-I2S_WORD_W:0] top_bits;

    // The value fits in 24 bits only when everything above bit 22 is a copy of the sign.
    always_comb begin
        shifted  = EXT_W'($signed(sample_i)) <<< GAIN_SHIFT;
        top_bits = shifted[EXT_W-1:I2S_WORD_W-1];
        if ((top_bits == '0) || (top_bits == '1)) begin
            word_o = shifted[I2S_WORD_W-1:0];
        end else if (shifted[EXT_W-1]) begin
            word_o = 24'h800000;
        end else begin
            word_o = 24'h7FFFFF;
        end
    end
`else
    assign word_o = I2S_WORD_W'($signed(sample_i)) << GAIN_SHIFT;
`endif

endmodule

// File: rtl/audio_i2s_out.sv
// I2S transmitter that paces the PSG with a per-frame next_sample strobe and serialises its L/R mix.
// Overflow handling of the gain stage follows AUDIO_I2S_SATURATE_EN (see audio_sample_conv).
module audio_i2s_out
    import audio_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int IN_W       = 19,
    parameter int GAIN_SHIFT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] left_in,
    input  logic [IN_W-1:0] right_in,
    output logic            next_sample,
    output logic            i2s_bck,
    output logic            i2s_lrck,
    output logic            i2s_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             bck_q, bck_d;
    logic             lrck_q, lrck_d;
    logic             data_q, data_d;
    logic             strobe_q, strobe_d;
    frame_t           frame_q, frame_d;

    dac_word_t        left_word, right_word;
    logic             tick, fall;
    logic [5:0]       bit_next, bit_idx;

    audio_sample_conv #(.IN_W(IN_W), .GAIN_SHIFT(GAIN_SHIFT)) u_conv_left (
        .sample_i (left_in),
        .word_o   (left_word)
    );

    audio_sample_conv #(.IN_W(IN_W), .GAIN_SHIFT(GAIN_SHIFT)) u_conv_right (
        .sample_i (right_in),
        .word_o   (right_word)
    );

    // Everything moves on a bck fall; slot n carries W[64-n], and 64-n mod 64 is just -n.
    always_comb begin
        tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        fall      = tick & bck_q;
        bit_next  = bit_cnt_q + 6'd1;
        bit_idx   = 6'd0 - bit_next;

        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        bck_d     = tick ? ~bck_q : bck_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        frame_d   = frame_q;

        if (fall) begin
            bit_cnt_d = bit_next;
            lrck_d    = bit_next[5];
            if (bit_next == 6'd0) begin
                strobe_d = 1'b1;
                frame_d  = pack_frame(left_word, right_word);
                data_d   = 1'b0;
            end else begin
                data_d   = frame_q[bit_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= I2S_BITCNT_RST;
            bck_q     <= 1'b0;
            lrck_q    <= 1'b1;
            data_q    <= 1'b0;
            strobe_q  <= 1'b0;
            frame_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bck_q     <= bck_d;
            lrck_q    <= lrck_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            frame_q   <= frame_d;
        end
    end

    assign next_sample = strobe_q;
    assign i2s_bck     = bck_q;
    assign i2s_lrck    = lrck_q;
    assign i2s_data    = data_q;

endmodule

// File: doc/audio_i2s_out.md
# audio_i2s_out

Audio output stage that sits directly downstream of the PSG. It paces the PSG by issuing the one-cycle `next_sample` strobe once per audio frame. On that same edge it latches the PSG's signed 19-bit left/right mix, converts each channel to a 24-bit DAC word, and serialises both as a standard I2S stream (bit clock, word select, data) toward the external DAC. Frame timing is derived entirely from the system clock by integer division.

## Interface
- `CLK_DIV`, default 4: system clocks per bit-clock half period; must be ≥ 1. Frame length is 128·`CLK_DIV` clocks.
- `IN_W`, default 19: input sample width, signed two's complement.
- `GAIN_SHIFT`, default 5: left shift applied to the sign-extended input; valid range 0–8.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `left_in`  in  `IN_W`  signed left sample (PSG `left_audio`).
- `right_in`  in  `IN_W`  signed right sample (PSG `right_audio`).
- `next_sample`  out  1  one-clock strobe at each frame start; drives PSG `next_sample`.
- `i2s_bck`  out  1  bit clock.
- `i2s_lrck`  out  1  word select: 0 = left slot, 1 = right slot.
- `i2s_data`  out  1  serial data, MSB first.

## Operation
- Divider `div_cnt` runs 0..`CLK_DIV`-1. On the cycle where `div_cnt`==`CLK_DIV`-1 it wraps to 0 and `i2s_bck` toggles.
- On a falling toggle (`bck` 1→0), `bit_cnt` (6 bits) increments mod 64. `i2s_lrck` ← new `bit_cnt[5]`. `i2s_data` is updated per the frame word.
- Frame word: W = {L24, 8'h00, R24, 8'h00}, 64 bits.
- Slot n = new `bit_cnt`:
  - n = 0: `i2s_data` = 0.
  - n = 1..63: `i2s_data` = W[64−n]. This gives the standard I2S one-bit delay after each `lrck` edge.
- Frame start is a falling toggle with new `bit_cnt` = 0. On that edge:
  - `next_sample` is registered to 1 for exactly one cycle.
  - W is loaded from the current `left_in`/`right_in` through conversion.
  - W is stable for the whole frame.
- Conversion, per channel:
  - Sign-extend to 24+`GAIN_SHIFT` bits, then shift left by `GAIN_SHIFT`.
  - Reduce to 24 bits as selected by the Configuration macro.
- Latency: the PSG computes after strobe k and holds its result. That result is captured at strobe k+1 and serialised during frame k+1. End-to-end latency is one frame.
- The PSG needs ≤ 100 cycles per sample. `CLK_DIV` ≥ 1 guarantees ≥ 128 cycles per frame.

## Timing
- Reset values: `div_cnt`=0, `bit_cnt`=63, `i2s_bck`=0, `i2s_lrck`=1, `i2s_data`=0, `next_sample`=0, W=0.
- Reset mid-frame: all state returns to the reset values above on the next edge. The partial frame is abandoned and no strobe is emitted during reset.
- The first falling toggle occurs 2·`CLK_DIV` clocks after `rst` is sampled low. `next_sample` is high during that cycle. Inputs are sampled on the same edge.
- `bck` rising edges fall mid-bit. Data and `lrck` change only with a `bck` fall, on the same clock edge.
- Consecutive `next_sample` pulses are exactly 128·`CLK_DIV` clocks apart. There is never a back-to-back assertion.
- `CLK_DIV`=1: `bck` toggles every clock; all rules above still hold.
- Input changes between strobes are ignored. The PSG updates `left_audio` mid-frame, and that does not disturb the frame in flight.

## Configuration
- `AUDIO_I2S_SATURATE_EN` defined: shifted values above 2^23−1 clamp to 24'h7FFFFF, and values below −2^23 clamp to 24'h800000.
- `AUDIO_I2S_SATURATE_EN` undefined: the low 24 bits are taken; overflow wraps.
- With `GAIN_SHIFT` ≤ 24−`IN_W`, both builds are bit-identical.

## Structure
- Package `audio_pkg`:
  - Constants `I2S_SLOT_BITS`=32, `I2S_WORD_W`=24, `I2S_FRAME_BITS`=64.
  - Reset constant `I2S_BITCNT_RST`=63.
- One sub-module, `audio_sample_conv`: combinational sign-extend, shift and saturate/wrap. It is instantiated once per channel and carries the `AUDIO_I2S_SATURATE_EN` guard.
- Top holds the divider, bit counter, W register and output registers.

## Test plan
- Reset release, `CLK_DIV`=4 → first `next_sample` at cycle 8, then every 512 cycles. `bck` period is 8 clocks and `lrck` period is 512 clocks.
- `left_in`=19'h00001, `right_in`=19'h7FFFF, `GAIN_SHIFT`=5 → left slot carries 24'h000020 and right slot carries 24'hFFFFE0, both MSB first one bit after the `lrck` edge. Bits 25–31 of each slot are 0.
- `left_in`=19'h3FFFF, `GAIN_SHIFT`=8 → with `AUDIO_I2S_SATURATE_EN` the word is 24'h7FFFFF; without it the word is 24'hFFFF00.
- Change `left_in` mid-frame from 19'h00100 to 19'h00200 → the current frame still serialises 24'h002000; the next frame serialises 24'h004000.
- Assert `rst` at `bit_cnt`=40 → outputs equal reset values on the following cycle. The next strobe comes 8 cycles after release.
- `CLK_DIV`=1 → strobes 128 cycles apart, `bck` toggles every cycle, and data matches W[64−n].
